// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz timing constants, count width and the
// display-phase enum shared by the horizontal and vertical sequencers.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_DIV      = 4;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  // Phase transition on the count value that is about to be registered.
  function automatic phase_e next_phase(input phase_e cur,
                                        input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] fp_at,
                                        input logic [CNT_W-1:0] sync_at,
                                        input logic [CNT_W-1:0] bp_at);
    next_phase = cur;
    case (cur)
      PH_ACT:  if (cnt == fp_at)   next_phase = PH_FP;
      PH_FP:   if (cnt == sync_at) next_phase = PH_SYNC;
      PH_SYNC: if (cnt == bp_at)   next_phase = PH_BP;
      PH_BP:   if (cnt == '0)      next_phase = PH_ACT;
      default: next_phase = PH_BP;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock into a one-cycle pixel-advance
// pulse every DIV clocks.
//   clk, reset (async, active-high), en (low = idle, counter cleared)
//   tick_c   : combinational "pix_tick will be high next cycle"
//   pix_tick : registered pixel-advance enable
module pixel_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick_c,
  output logic pix_tick
);

  localparam int unsigned   DW       = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_tick_q, pix_tick_d;

  // Counter runs 0..DIV-1; the wrap cycle is the tick.
  always_comb begin
    tick_c     = en && (div_cnt_q == DIV_LAST);
    div_cnt_d  = '0;
    if (en && !tick_c) div_cnt_d = div_cnt_q + DW'(1);
    pix_tick_d = tick_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 Hz raster timing from the 100 MHz system clock.
//   clk, reset (async, active-high), en (low = synchronous idle)
//   pix_tick               : one-clk pixel-advance pulse every DIV clks
//   x, y                   : raster position, change only with pix_tick
//   video_on, hsync, vsync : decoded from the position, aligned with x/y
//   line_start/frame_start : one-clk strobes when x / (x,y) become 0
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned DIV      = VGA_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_FP_AT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_AT = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BP_AT   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_FP_AT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_AT = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BP_AT   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic tick_c;

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  phase_e           h_ph_q, h_ph_d, v_ph_q, v_ph_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  pixel_tick_gen #(
    .DIV (DIV)
  ) u_pixel_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .tick_c   (tick_c),
    .pix_tick (pix_tick)
  );

  // Counters, phase sequencers and decode; everything is computed from the
  // next count so registered outputs line up with x/y in the same cycle.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    h_ph_d        = h_ph_q;
    v_ph_d        = v_ph_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (!en) begin
      x_d        = H_LAST;
      y_d        = V_LAST;
      h_ph_d     = PH_BP;
      v_ph_d     = PH_BP;
      video_on_d = 1'b0;
      hsync_d    = ~SYNC_ACT;
      vsync_d    = ~SYNC_ACT;
    end else if (tick_c) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end

      h_ph_d = next_phase(h_ph_q, x_d, H_FP_AT, H_SYNC_AT, H_BP_AT);
      v_ph_d = next_phase(v_ph_q, y_d, V_FP_AT, V_SYNC_AT, V_BP_AT);

      video_on_d    = (h_ph_d == PH_ACT) && (v_ph_d == PH_ACT);
      hsync_d       = (h_ph_d == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      vsync_d       = (v_ph_d == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      h_ph_q        <= PH_BP;
      v_ph_q        <= PH_BP;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      h_ph_q        <= h_ph_d;
      v_ph_q        <= v_ph_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size 640x480 instance plus a tiny
// instance (DIV=2, active-high sync) so whole frames fit in a short run.
module tb_vga_timing_ctrl;

  typedef struct {
    logic tick;
    int   x;
    int   y;
    logic von;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic       pix_tick0, video_on0, hsync0, vsync0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       pix_tick1, video_on1, hsync1, vsync1, ls1, fs1;
  logic [9:0] x1, y1;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-instance timing: [0] = 640x480 default, [1] = tiny raster.
  int   c_div [2] = '{4, 2};
  int   c_ha  [2] = '{640, 10};
  int   c_hfp [2] = '{16, 2};
  int   c_hs  [2] = '{96, 3};
  int   c_hbp [2] = '{48, 2};
  int   c_va  [2] = '{480, 6};
  int   c_vfp [2] = '{10, 2};
  int   c_vs  [2] = '{2, 2};
  int   c_vbp [2] = '{33, 3};
  logic c_sa  [2] = '{1'b0, 1'b1};

  int m_div [2];
  int m_x   [2];
  int m_y   [2];

  exp_t q0[$];
  exp_t q1[$];

  vga_timing_ctrl u_dut (
    .clk         (clk),
    .reset       (rst),
    .en          (en),
    .pix_tick    (pix_tick0),
    .x           (x0),
    .y           (y0),
    .video_on    (video_on0),
    .hsync       (hsync0),
    .vsync       (vsync0),
    .line_start  (ls0),
    .frame_start (fs0)
  );

  vga_timing_ctrl #(
    .DIV (2), .H_ACTIVE (10), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3), .SYNC_ACT (1'b1)
  ) u_small (
    .clk         (clk),
    .reset       (rst),
    .en          (en),
    .pix_tick    (pix_tick1),
    .x           (x1),
    .y           (y1),
    .video_on    (video_on1),
    .hsync       (hsync1),
    .vsync       (vsync1),
    .line_start  (ls1),
    .frame_start (fs1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_all(input string p, input exp_t e, input logic pt,
                         input logic [9:0] xx, input logic [9:0] yy,
                         input logic von, input logic hs, input logic vs,
                         input logic ls, input logic fs);
    chk({p, ".pix_tick"},    32'(pt),  32'(e.tick));
    chk({p, ".x"},           32'(xx),  e.x);
    chk({p, ".y"},           32'(yy),  e.y);
    chk({p, ".video_on"},    32'(von), 32'(e.von));
    chk({p, ".hsync"},       32'(hs),  32'(e.hs));
    chk({p, ".vsync"},       32'(vs),  32'(e.vs));
    chk({p, ".line_start"},  32'(ls),  32'(e.ls));
    chk({p, ".frame_start"}, 32'(fs),  32'(e.fs));
  endtask

  // Reference model: advances on every clock (or async reset) and queues the
  // outputs it expects to see for that cycle.
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_div[i] = 0;
      m_x[i]   = c_ha[i] + c_hfp[i] + c_hs[i] + c_hbp[i] - 1;
      m_y[i]   = c_va[i] + c_vfp[i] + c_vs[i] + c_vbp[i] - 1;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        int   htot;
        int   vtot;
        htot = c_ha[i] + c_hfp[i] + c_hs[i] + c_hbp[i];
        vtot = c_va[i] + c_vfp[i] + c_vs[i] + c_vbp[i];
        e.tick = 1'b0;
        e.ls   = 1'b0;
        e.fs   = 1'b0;
        if (rst || !en) begin
          m_div[i] = 0;
          m_x[i]   = htot - 1;
          m_y[i]   = vtot - 1;
        end else begin
          e.tick   = (m_div[i] == c_div[i] - 1);
          m_div[i] = e.tick ? 0 : m_div[i] + 1;
          if (e.tick) begin
            if (m_x[i] == htot - 1) begin
              m_x[i] = 0;
              m_y[i] = (m_y[i] == vtot - 1) ? 0 : m_y[i] + 1;
            end else begin
              m_x[i] = m_x[i] + 1;
            end
            e.ls = (m_x[i] == 0);
            e.fs = (m_x[i] == 0) && (m_y[i] == 0);
          end
        end
        e.x   = m_x[i];
        e.y   = m_y[i];
        e.von = (m_x[i] < c_ha[i]) && (m_y[i] < c_va[i]);
        e.hs  = (m_x[i] >= c_ha[i] + c_hfp[i] && m_x[i] < c_ha[i] + c_hfp[i] + c_hs[i])
                ? c_sa[i] : ~c_sa[i];
        e.vs  = (m_y[i] >= c_va[i] + c_vfp[i] && m_y[i] < c_va[i] + c_vfp[i] + c_vs[i])
                ? c_sa[i] : ~c_sa[i];
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  end

  // Scoreboard: compare the newest expectation against the DUTs mid-cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q0.size() > 0) begin
      while (q0.size() > 1) void'(q0.pop_front());
      e = q0.pop_front();
      cmp_all("big", e, pix_tick0, x0, y0, video_on0, hsync0, vsync0, ls0, fs0);
    end
    if (q1.size() > 0) begin
      while (q1.size() > 1) void'(q1.pop_front());
      e = q1.pop_front();
      cmp_all("small", e, pix_tick1, x1, y1, video_on1, hsync1, vsync1, ls1, fs1);
    end
  end

  // Tiny raster: frame period 13*17 ticks * 2 clks, vsync for 2 lines.
  initial begin
    int  clks   = 0;
    int  vs_cnt = 0;
    logic have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !en) begin
        have_prev = 1'b0;
      end else begin
        clks++;
        if (pix_tick1 && vsync1) vs_cnt++;
        if (fs1) begin
          if (have_prev) begin
            chk("small.frame_period_clks", clks, 442);
            chk("small.vsync_ticks", vs_cnt, 34);
          end
          have_prev = 1'b1;
          clks      = 0;
          vs_cnt    = 0;
        end
      end
    end
  end

  // Wait for the next big-instance pix_tick, sampled 1 time unit after the edge.
  task automatic wait_tick(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (pix_tick0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int   n_clk;
    int   prev_x;
    logic prev_von, prev_hs, ok, reached;
    int   von_fall_x, hs_fall_x, hs_rise_x, hs_low;

    #1;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.x", 32'(x0), 799);
    chk("rst.y", 32'(y0), 524);
    chk("rst.hsync", 32'(hsync0), 1);
    chk("rst.vsync", 32'(vsync0), 1);
    chk("rst.video_on", 32'(video_on0), 0);
    #1;
    rst = 1'b0;

    n_clk = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (pix_tick0) begin
        n_clk = n;
        break;
      end
    end
    chk("first_tick_clk", n_clk, 4);
    chk("first.x", 32'(x0), 0);
    chk("first.y", 32'(y0), 0);
    chk("first.video_on", 32'(video_on0), 1);
    chk("first.line_start", 32'(ls0), 1);
    chk("first.frame_start", 32'(fs0), 1);

    n_clk = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (pix_tick0) begin
        n_clk = n;
        break;
      end
    end
    chk("tick_period_clk", n_clk, 4);

    // Sweep lines until (300,10), recording line-0 decode edges.
    prev_x     = 32'(x0);
    prev_von   = video_on0;
    prev_hs    = hsync0;
    von_fall_x = -1;
    hs_fall_x  = -1;
    hs_rise_x  = -1;
    hs_low     = 0;
    reached    = (x0 == 10'd300) && (y0 == 10'd10);
    for (int n = 0; n < 20000 && !reached; n++) begin
      wait_tick(ok);
      if (!ok) break;
      if (y0 == 10'd0) begin
        if (prev_von && !video_on0) von_fall_x = 32'(x0);
        if (prev_hs && !hsync0)     hs_fall_x  = 32'(x0);
        if (!prev_hs && hsync0)     hs_rise_x  = 32'(x0);
        if (!hsync0)                hs_low++;
      end
      if (x0 == 10'd0 && y0 == 10'd1) begin
        chk("wrap.prev_x", prev_x, 799);
        chk("wrap.line_start", 32'(ls0), 1);
        chk("wrap.frame_start", 32'(fs0), 0);
      end
      prev_x   = 32'(x0);
      prev_von = video_on0;
      prev_hs  = hsync0;
      reached  = (x0 == 10'd300) && (y0 == 10'd10);
    end
    chk("reach_x300_y10", 32'(reached), 1);
    chk("line0.video_on_fall_x", von_fall_x, 640);
    chk("line0.hsync_fall_x", hs_fall_x, 656);
    chk("line0.hsync_rise_x", hs_rise_x, 752);
    chk("line0.hsync_low_ticks", hs_low, 96);

    // Drop en mid-line: idle on the very next edge and stay there.
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("en_off.x", 32'(x0), 799);
    chk("en_off.y", 32'(y0), 524);
    chk("en_off.hsync", 32'(hsync0), 1);
    chk("en_off.vsync", 32'(vsync0), 1);
    chk("en_off.pix_tick", 32'(pix_tick0), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("en_hold.x", 32'(x0), 799);
    chk("en_hold.y", 32'(y0), 524);

    en    = 1'b1;
    n_clk = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (fs0) begin
        n_clk = n;
        break;
      end
    end
    chk("en_on.frame_start_clk", n_clk, 4);

    // Async reset in the middle of hsync.
    reached = (x0 == 10'd700);
    for (int n = 0; n < 1000 && !reached; n++) begin
      wait_tick(ok);
      if (!ok) break;
      reached = (x0 == 10'd700);
    end
    chk("reach_x700", 32'(reached), 1);
    chk("x700.hsync", 32'(hsync0), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.x", 32'(x0), 799);
    chk("async_rst.hsync", 32'(hsync0), 1);
    chk("async_rst.video_on", 32'(video_on0), 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Sequences the 640x480@60 Hz display path from the 100 MHz system clock. Generates a one-cycle 25 MHz pixel-enable tick (replaces free-running divided clock for logic use), horizontal/vertical counters, sync pulses, active-video flag and line/frame strobes. Sits between the system clock and the sprite/pixel pipeline; all downstream sprite logic qualifies on pix_tick.

Parameters:
DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz); >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACT, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
en  input  1  run enable; low forces idle (reset-equivalent) state synchronously
pix_tick  output  1  one-clk pulse every DIV clks; pixel-advance enable
x  output  10  current horizontal count, 0..H_TOTAL-1
y  output  10  current vertical count, 0..V_TOTAL-1
video_on  output  1  high when x < H_ACTIVE and y < V_ACTIVE
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
line_start  output  1  one-clk pulse, coincident with pix_tick, when x becomes 0
frame_start  output  1  one-clk pulse, coincident with pix_tick, when (x,y) becomes (0,0)

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525); both must be <= 1024.
- Reset (async, immediate) and en=0 (next clk edge): div_cnt=0, x=H_TOTAL-1, y=V_TOTAL-1, pix_tick=0, video_on=0, hsync=vsync=~SYNC_ACT, line_start=frame_start=0.
- div_cnt counts 0..DIV-1 while en=1; pix_tick=1 in the cycle div_cnt==DIV-1 is registered, i.e. first pix_tick DIV clks after reset release / en rise, then every DIV clks.
- All outputs registered and mutually consistent: x, y, video_on, hsync, vsync, strobes change only in the pix_tick cycle and hold for DIV clks.
- On pix_tick: x = (x==H_TOTAL-1) ? 0 : x+1; y increments (wrapping at V_TOTAL-1 to 0) only when x wraps.
- Horizontal FSM H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT, transitions at x = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, 0 respectively; vertical FSM identical on y. Reset state: H_BP / V_BP.
- hsync = SYNC_ACT iff x in [656,752) (H FSM in H_SYNC); vsync = SYNC_ACT iff y in [490,492).
- Decode uses next-count values so outputs align with x/y in the same cycle (zero extra latency).
- First tick after reset/en: x=0, y=0, video_on=1, line_start=1, frame_start=1.
- en falling mid-line: no partial completion; idle on next edge. en held low indefinitely: outputs static at reset values.
- reset asserted mid-operation overrides en and all counters asynchronously.

Decomposition:
- Package vga_timing_pkg: 640x480 timing constants, H_TOTAL/V_TOTAL, phase enum (ACT, FP, SYNC, BP), count width (10).
- Sub-module pixel_tick_gen (div_cnt, en, pix_tick); the H/V FSMs and decode stay in vga_timing_ctrl.

Test Plan:
- Release reset with en=1 -> pix_tick first at clk 4, period 4; at that tick x=0, y=0, video_on=1, frame_start=1, line_start=1.
- Sweep one line -> video_on falls at x=640; hsync low for exactly 96 ticks starting x=656; rises at x=752.
- Line wrap x=799 -> x=0, y increments by 1, line_start=1 and frame_start=0 for that tick.
- Full frame -> vsync low for y=490..491 (1600 ticks); frame_start period 420000 ticks = 1,680,000 clks.
- Deassert en at x=300,y=10 -> next edge x=799, y=524, syncs high, pix_tick=0; reassert -> frame_start 4 clks later.
- Assert reset mid-hsync (x=700) between clk edges -> hsync=1, video_on=0, x=799 immediately without a clock edge.
